// File: rtl/xor_gate_bus_pipelined.sv
// Multi-input bus XOR with per-input inversion, parity/one-hot reduction,
// a 2-stage valid/ready pipeline and a running XOR accumulator of delivered results.
module xor_gate_bus_pipelined #(
  parameter int                    NrOfBits    = 8,
  parameter int                    NrOfInputs  = 3,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0,
  parameter int                    OneHotMode  = 0
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [NrOfInputs*NrOfBits-1:0] Inputs,
  input  logic                           InValid,
  output logic                           InReady,
  output logic [NrOfBits-1:0]            Result,
  output logic                           OutValid,
  input  logic                           OutReady,
  input  logic                           AccClear,
  output logic [NrOfBits-1:0]            Accumulator
);

  function automatic logic [NrOfInputs*NrOfBits-1:0] apply_bubbles(
    input logic [NrOfInputs*NrOfBits-1:0] v
  );
    logic [NrOfInputs*NrOfBits-1:0] r;
    r = v;
    for (int i = 0; i < NrOfInputs; i++) begin
      r[i*NrOfBits +: NrOfBits] = v[i*NrOfBits +: NrOfBits] ^ {NrOfBits{BubblesMask[i]}};
    end
    return r;
  endfunction

  // One-hot is tracked as "seen at least once" minus "seen at least twice",
  // which avoids building a per-bit population counter.
  function automatic logic [NrOfBits-1:0] reduce_f(
    input logic [NrOfInputs*NrOfBits-1:0] v
  );
    logic [NrOfBits-1:0] par;
    logic [NrOfBits-1:0] seen;
    logic [NrOfBits-1:0] multi;
    par   = '0;
    seen  = '0;
    multi = '0;
    for (int i = 0; i < NrOfInputs; i++) begin
      multi = multi | (seen & v[i*NrOfBits +: NrOfBits]);
      seen  = seen | v[i*NrOfBits +: NrOfBits];
      par   = par ^ v[i*NrOfBits +: NrOfBits];
    end
    return (OneHotMode != 0) ? (seen & ~multi) : par;
  endfunction

  logic                           vld_p1_q, vld_p1_d;
  logic [NrOfInputs*NrOfBits-1:0] data_p1_q, data_p1_d;
  logic                           vld_p2_q, vld_p2_d;
  logic [NrOfBits-1:0]            res_p2_q, res_p2_d;
  logic [NrOfBits-1:0]            acc_q, acc_d;
  logic                           adv_p1;
  logic                           accept_p0;
  logic                           xfer_p2;

  assign adv_p1    = !vld_p2_q || OutReady;
  assign InReady   = !vld_p1_q || adv_p1;
  assign accept_p0 = InValid && InReady;
  assign xfer_p2   = vld_p2_q && OutReady;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    data_p1_d = data_p1_q;
    vld_p2_d  = vld_p2_q;
    res_p2_d  = res_p2_q;
    acc_d     = acc_q;

    // Stage 1: capture inverted operands
    if (accept_p0) begin
      data_p1_d = apply_bubbles(Inputs);
      vld_p1_d  = 1'b1;
    end else if (adv_p1) begin
      vld_p1_d  = 1'b0;
    end

    // Stage 2: reduce; Result keeps its last value across bubbles
    if (adv_p1) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        res_p2_d = reduce_f(data_p1_q);
      end
    end

    // Clear takes effect before folding a coincident delivery
    if (xfer_p2) begin
      acc_d = (AccClear ? '0 : acc_q) ^ res_p2_q;
    end else if (AccClear) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      res_p2_q  <= '0;
      acc_q     <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
      vld_p2_q  <= vld_p2_d;
      res_p2_q  <= res_p2_d;
      acc_q     <= acc_d;
    end
  end

  assign Result      = res_p2_q;
  assign OutValid    = vld_p2_q;
  assign Accumulator = acc_q;

endmodule

// File: tb/tb_xor_gate_bus_pipelined.sv
// Scoreboard bench: three instances (parity, one-hot, bubble mask 001) share one
// stimulus stream; expected results from a hand-computed vector table.
module tb_xor_gate_bus_pipelined;
  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N*W-1:0] ins;
  logic           in_vld, ordy, acc_clr;
  logic           ir_par, ir_oh, ir_bub;
  logic           ov_par, ov_oh, ov_bub;
  logic [W-1:0]   res_par, res_oh, res_bub;
  logic [W-1:0]   acc_par, acc_oh, acc_bub;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q_par[$];
  logic [W-1:0] q_oh[$];
  logic [W-1:0] q_bub[$];

  typedef struct {
    logic [7:0] a, b, c, e_par, e_oh, e_bub;
  } vec_t;
  vec_t vt[6];

  xor_gate_bus_pipelined #(.NrOfBits(W), .NrOfInputs(N), .BubblesMask(3'b000), .OneHotMode(0)) u_par (
    .Clock(clk), .Reset(rst), .Inputs(ins), .InValid(in_vld), .InReady(ir_par),
    .Result(res_par), .OutValid(ov_par), .OutReady(ordy), .AccClear(acc_clr), .Accumulator(acc_par));
  xor_gate_bus_pipelined #(.NrOfBits(W), .NrOfInputs(N), .BubblesMask(3'b000), .OneHotMode(1)) u_oh (
    .Clock(clk), .Reset(rst), .Inputs(ins), .InValid(in_vld), .InReady(ir_oh),
    .Result(res_oh), .OutValid(ov_oh), .OutReady(ordy), .AccClear(acc_clr), .Accumulator(acc_oh));
  xor_gate_bus_pipelined #(.NrOfBits(W), .NrOfInputs(N), .BubblesMask(3'b001), .OneHotMode(0)) u_bub (
    .Clock(clk), .Reset(rst), .Inputs(ins), .InValid(in_vld), .InReady(ir_bub),
    .Result(res_bub), .OutValid(ov_bub), .OutReady(ordy), .AccClear(acc_clr), .Accumulator(acc_bub));

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=output exp=none", name);
  endtask

  // Drive one cycle; push expectations for operands accepted at the coming edge.
  task automatic tick(input int vi, input bit vld, input bit r, input bit clr, input bit rs,
                      output bit took, output bit irs);
    in_vld  = vld;
    ins     = vld ? {vt[vi].c, vt[vi].b, vt[vi].a} : N*W'($urandom);
    ordy    = r;
    acc_clr = clr;
    rst     = rs;
    @(negedge clk);
    irs  = ir_par;
    took = vld && ir_par && !rs;
    if (took) begin
      q_par.push_back(vt[vi].e_par);
      q_oh.push_back(vt[vi].e_oh);
      q_bub.push_back(vt[vi].e_bub);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int vi, input bit vld, input bit r, input bit clr, input bit rs);
    bit t, i;
    tick(vi, vld, r, clr, rs, t, i);
  endtask

  // Monitor: pop on every delivery, and check stall stability.
  logic         stall_prev = 1'b0;
  logic         rst_prev   = 1'b1;
  logic [W-1:0] held_par   = '0;
  always @(negedge clk) begin
    if (!rst && ov_par === 1'b1 && ordy) begin
      if (q_par.size() == 0) fail_now("unexpected_delivery");
      else begin
        chk("deliver_par", res_par, q_par.pop_front());
        chk("deliver_oh", res_oh, q_oh.pop_front());
        chk("deliver_bub", res_bub, q_bub.pop_front());
        chk("ov_match", {6'b0, ov_oh, ov_bub}, 8'h03);
      end
    end
    if (stall_prev && !rst_prev) begin
      chk("stall_hold_vld", 8'(ov_par), 8'h01);
      chk("stall_hold_res", res_par, held_par);
    end
    stall_prev <= (ov_par === 1'b1) && !ordy;
    held_par   <= res_par;
    rst_prev   <= rst;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  bp_vec[4];
    int  bp_idx;
    int  seq[4];
    bit  took, irs;

    vt[0] = '{8'h0F, 8'h33, 8'h55, 8'h69, 8'h68, 8'h96};
    vt[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    vt[2] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h55};
    vt[3] = '{8'h01, 8'h02, 8'h04, 8'h07, 8'h07, 8'hF8};
    vt[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    vt[5] = '{8'hF0, 8'h33, 8'h55, 8'h96, 8'h86, 8'h69};

    rst = 1'b1; in_vld = 1'b0; ordy = 1'b1; acc_clr = 1'b0; ins = '0;
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("rst_ov", 8'(ov_par), 8'h00);
    chk("rst_res", res_par, 8'h00);
    chk("rst_acc", acc_par, 8'h00);
    chk("rst_ir", 8'(ir_par), 8'h01);

    // Latency: one pulse, result visible after the second edge only
    step(0, 1, 1, 0, 0);
    chk("lat_ov_e0", 8'(ov_par), 8'h00);
    step(0, 0, 1, 0, 0);
    chk("lat_ov_e1", 8'(ov_par), 8'h01);
    chk("lat_res_par", res_par, 8'h69);
    chk("lat_res_oh", res_oh, 8'h68);
    chk("lat_res_bub", res_bub, 8'h96);
    step(0, 0, 1, 0, 0);
    chk("lat_ov_e2", 8'(ov_par), 8'h00);
    chk("res_hold_idle", res_par, 8'h69);

    // Bubble mid-stream
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("bub_ov_a", 8'(ov_par), 8'h01);
    step(2, 1, 1, 0, 0);
    chk("bub_ov_gap", 8'(ov_par), 8'h00);
    step(0, 0, 1, 0, 0);
    chk("bub_ov_b", 8'(ov_par), 8'h01);
    step(0, 0, 1, 0, 0);

    // Full throughput
    seq = '{3, 4, 5, 0};
    for (int j = 0; j < 4; j++) begin
      tick(seq[j], 1, 1, 0, 0, took, irs);
      chk("tput_accept", 8'(took), 8'h01);
      if (j > 0) chk("tput_ov", 8'(ov_par), 8'h01);
    end
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("tput_drain", 8'(ov_par), 8'h00);

    // Backpressure: OutReady low for cycles 2-5
    bp_vec = '{0, 1, 2, 3};
    bp_idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick(bp_idx < 4 ? bp_vec[bp_idx] : 0, bp_idx < 4, !(cyc >= 2 && cyc <= 5), 0, 0, took, irs);
      if (took) bp_idx++;
      if (cyc >= 2 && cyc <= 5) chk("bp_inready_low", 8'(irs), 8'h00);
      if (cyc == 6) chk("bp_inready_back", 8'(irs), 8'h01);
    end
    chk("bp_all_sent", 8'(bp_idx), 8'h04);
    chk("bp_drained", 8'(q_par.size()), 8'h00);

    // Accumulator
    step(0, 0, 1, 1, 0);
    chk("acc_clear0", acc_par, 8'h00);
    step(0, 1, 1, 0, 0);
    step(5, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("acc_ff_par", acc_par, 8'hFF);
    chk("acc_oh", acc_oh, 8'hEE);
    chk("acc_bub", acc_bub, 8'hFF);

    // Reset with both stages full and Accumulator=0xFF
    step(0, 1, 0, 0, 0);
    step(5, 1, 0, 0, 0);
    chk("pre_rst_ov", 8'(ov_par), 8'h01);
    chk("pre_rst_acc", acc_par, 8'hFF);
    step(0, 0, 0, 0, 1);
    q_par.delete(); q_oh.delete(); q_bub.delete();
    chk("mrst_ov", 8'(ov_par), 8'h00);
    chk("mrst_res", res_par, 8'h00);
    chk("mrst_acc", acc_par, 8'h00);
    chk("mrst_ir", 8'(ir_par), 8'h01);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 1, 0, 0);
      chk("mrst_no_stale", 8'(ov_par), 8'h00);
    end

    // Clear coincident with a delivery, then clear alone
    step(5, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("acc_96", acc_par, 8'h96);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("acc_clr_fold", acc_par, 8'h69);
    step(0, 0, 1, 1, 0);
    chk("acc_clr_only", acc_par, 8'h00);

    chk("end_queue_empty", 8'(q_par.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
